pc_fetch: RTL

PC_FETCH -- requirements
Module: pc_fetch

---
 rtl/pc_fetch_pkg.sv | 32 +++
 rtl/pc_fetch_skid_buf.sv | 40 ++++
 rtl/pc_fetch.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encodings,
// reset vector, instruction width and small PC helpers.
package pc_fetch_pkg;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;

  // First fetch address out of reset (MIPS boot ROM vector).
  localparam logic [ADDR_W-1:0] PC_RESET_DEFAULT = 32'hBFC0_0000;

  // Clears the byte-offset bits so every fetch address is word aligned.
  localparam logic [ADDR_W-1:0] WORD_MASK = 32'hFFFF_FFFC;

  // REQ : request on the bus
  // WAIT: one accepted request outstanding
  // FULL: response parked in the skid buffer while ID is stalled
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_FULL = 2'd2
  } fetch_state_e;

  // Sequential successor; wraps silently at 2^32.
  function automatic logic [ADDR_W-1:0] pc_next(input logic [ADDR_W-1:0] pc);
    return pc + 32'd4;
  endfunction

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return a & WORD_MASK;
  endfunction

endpackage

// File: rtl/pc_fetch_skid_buf.sv
// fetch_skid_buf: one-entry holding register for an instruction that
// returned from memory while the ID stage was stalled.
module fetch_skid_buf
  import pc_fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic               i_clear,
  input  logic [ADDR_W-1:0]  i_pc,
  input  logic [INSTR_W-1:0] i_instr,
  output logic               o_valid,
  output logic [ADDR_W-1:0]  o_pc,
  output logic [INSTR_W-1:0] o_instr
);

  logic               r_valid;
  logic [ADDR_W-1:0]  r_pc;
  logic [INSTR_W-1:0] r_instr;

  // Capture on load, drop on clear (drained or discarded by the owner).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_instr <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc    <= i_pc;
      r_instr <= i_instr;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_instr = r_instr;

endmodule

// File: rtl/pc_fetch.sv
// pc_fetch: IF stage. Issues one instruction-memory request at a time,
// writes the IF/ID register, parks a response in a skid buffer while ID
// stalls, and handles redirects from the next-PC unit.
// Optional feature macro: BRANCH_DELAY_SLOT_EN -- when defined the
// instruction after a jump is still delivered before fetch moves to npc;
// when undefined everything sequential after the jump is squashed.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = PC_RESET_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               isJump,
  input  logic [ADDR_W-1:0]  npc,
  output logic               imemReq,
  output logic [ADDR_W-1:0]  imemAddr,
  input  logic               imemReady,
  input  logic               imemRvalid,
  input  logic [INSTR_W-1:0] imemRdata,
  output logic               ifidValid,
  output logic [ADDR_W-1:0]  ifidPc,
  output logic [INSTR_W-1:0] ifidInstr
);

  fetch_state_e       r_state;
  logic               r_req;      // registered imemReq; low for one cycle out of reset
  logic [ADDR_W-1:0]  r_pc;       // next address to request
  logic [ADDR_W-1:0]  r_addr;     // address of the outstanding request
  logic               r_drop;     // outstanding response belongs to a squashed path
  logic               r_ifid_valid;
  logic [ADDR_W-1:0]  r_ifid_pc;
  logic [INSTR_W-1:0] r_ifid_instr;
`ifdef BRANCH_DELAY_SLOT_EN
  logic [ADDR_W-1:0]  r_pend;     // jump target held until the slot is requested
  logic               r_pend_v;
`endif

  logic               w_accept;
  logic               w_jump;
  logic [ADDR_W-1:0]  w_npc;
  logic               w_keep;     // a response arriving with this jump may enter IF/ID
  logic               w_buf_load;
  logic               w_buf_clear;
  logic               w_buf_valid;
  logic [ADDR_W-1:0]  w_buf_pc;
  logic [INSTR_W-1:0] w_buf_instr;

  assign w_accept = r_req & imemReady;
  // A jump seen under stall is ignored; ID will present it again.
  assign w_jump   = isJump & ~stall;
  assign w_npc    = word_align(npc);
`ifdef BRANCH_DELAY_SLOT_EN
  // The word arriving alongside a jump is the delay slot: keep it.
  assign w_keep   = 1'b1;
`else
  assign w_keep   = ~isJump;
`endif

  // Park the response when ID cannot take it; release or discard on unstall.
  assign w_buf_load  = (r_state == S_WAIT) & imemRvalid & ~r_drop & stall;
  assign w_buf_clear = (r_state == S_FULL) & ~stall;

  fetch_skid_buf u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_buf_load),
    .i_clear (w_buf_clear),
    .i_pc    (r_addr),
    .i_instr (imemRdata),
    .o_valid (w_buf_valid),
    .o_pc    (w_buf_pc),
    .o_instr (w_buf_instr)
  );

  // Fetch FSM, fetch PC, redirect bookkeeping and the IF/ID register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_REQ;
      r_req        <= 1'b0;
      r_pc         <= RESET_PC;
      r_addr       <= '0;
      r_drop       <= 1'b0;
      r_ifid_valid <= 1'b0;
      r_ifid_pc    <= '0;
      r_ifid_instr <= '0;
`ifdef BRANCH_DELAY_SLOT_EN
      r_pend       <= '0;
      r_pend_v     <= 1'b0;
`endif
    end else begin
      // Bubble unless something below writes a live instruction.
      if (!stall) r_ifid_valid <= 1'b0;

      unique case (r_state)
        S_REQ: begin
          if (w_accept) begin
            r_state <= S_WAIT;
            r_req   <= 1'b0;
            r_addr  <= r_pc;
            if (w_jump) begin
              r_pc <= w_npc;
`ifdef BRANCH_DELAY_SLOT_EN
              // The request going out now is the delay slot itself.
              r_pend_v <= 1'b0;
`else
              // The request going out now is on the squashed path.
              r_drop <= 1'b1;
`endif
            end else begin
`ifdef BRANCH_DELAY_SLOT_EN
              r_pc     <= r_pend_v ? r_pend : pc_next(r_pc);
              r_pend_v <= 1'b0;
`else
              r_pc <= pc_next(r_pc);
`endif
            end
          end else begin
            // Also lifts imemReq on the first cycle out of reset.
            r_req <= 1'b1;
            if (w_jump) begin
`ifdef BRANCH_DELAY_SLOT_EN
              // Slot not yet requested: fetch it first, then the target.
              r_pend   <= w_npc;
              r_pend_v <= 1'b1;
`else
              r_pc <= w_npc;
`endif
            end
          end
        end

        S_WAIT: begin
          if (imemRvalid) begin
            r_drop  <= 1'b0;
            r_state <= S_REQ;
            r_req   <= 1'b1;
            if (!r_drop && stall) begin
              r_state <= S_FULL;
              r_req   <= 1'b0;
            end else if (!r_drop && w_keep) begin
              r_ifid_valid <= 1'b1;
              r_ifid_pc    <= r_addr;
              r_ifid_instr <= imemRdata;
            end
            if (w_jump) r_pc <= w_npc;
          end else if (w_jump) begin
            r_pc <= w_npc;
`ifndef BRANCH_DELAY_SLOT_EN
            r_drop <= 1'b1;
`endif
          end
        end

        S_FULL: begin
          if (!stall) begin
            r_state <= S_REQ;
            r_req   <= 1'b1;
            if (w_keep) begin
              r_ifid_valid <= w_buf_valid;
              r_ifid_pc    <= w_buf_pc;
              r_ifid_instr <= w_buf_instr;
            end
            if (w_jump) r_pc <= w_npc;
          end
        end

        default: begin
          r_state <= S_REQ;
          r_req   <= 1'b1;
        end
      endcase
    end
  end

  assign imemReq   = r_req;
  assign imemAddr  = word_align(r_pc);
  assign ifidValid = r_ifid_valid;
  assign ifidPc    = r_ifid_pc;
  assign ifidInstr = r_ifid_instr;

endmodule
